// File: rtl/uart_denetleyici_pkg.sv
// Shared register offsets, STAT bit positions and FSM state encoding for the UART peripheral.
package uart_denetleyici_pkg;

  localparam logic [7:0] UART_CTRL  = 8'h00;
  localparam logic [7:0] UART_STAT  = 8'h04;
  localparam logic [7:0] UART_RDATA = 8'h08;
  localparam logic [7:0] UART_WDATA = 8'h0C;

  localparam int STAT_TX_FULL   = 0;
  localparam int STAT_TX_EMPTY  = 1;
  localparam int STAT_RX_FULL   = 2;
  localparam int STAT_RX_EMPTY  = 3;
  localparam int STAT_FRAME_ERR = 4;
  localparam int STAT_OVERRUN   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // A divider below 2 would leave no room for the half-bit start re-check.
  function automatic logic [15:0] eff_baud_div(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/uart_denetleyici_fifo.sv
// Byte FIFO with combinational head; push accepted when full only if a pop happens in the same cycle.
// Zero-latency read of the head entry; writes to a full FIFO without a concurrent pop are dropped.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] ptr_t;

  logic [W-1:0] r_mem [DEPTH];
  ptr_t         r_wptr;
  ptr_t         r_rptr;
  cnt_t         r_cnt;
  logic         w_push;
  logic         w_pop;

  assign w_pop   = pop_i & (r_cnt != '0);
  assign w_push  = push_i & ((r_cnt != cnt_t'(DEPTH)) | w_pop);
  assign full_o  = (r_cnt == cnt_t'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign dout_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + ptr_t'(1);
      if (w_pop)  r_rptr <= r_rptr + ptr_t'(1);
      r_cnt <= r_cnt + cnt_t'(w_push) - cnt_t'(w_pop);
    end
  end

endmodule

// File: rtl/uart_denetleyici.sv
// Wishbone-slave 8N1 UART: ack one cycle after strobe, never back-to-back; TX/RX buffered in byte FIFOs.
// Bus is never stalled: a write to a full TX FIFO is dropped, an RX byte arriving into a full FIFO sets overrun.
module uart_denetleyici
  import uart_denetleyici_pkg::*;
#(
  parameter int FIFO_DEPTH       = 16,
  parameter int DEFAULT_BAUD_DIV = 868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [7:0]  adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  input  logic        uart_rx_i,
  output logic        uart_tx_o
);

  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_tx_en;
  logic        r_rx_en;
  logic [15:0] r_baud_div;
  logic        r_frame_err;
  logic        r_overrun;

  logic        w_acc, w_wr, w_rd;
  logic [31:0] w_rdata;
  logic [15:0] w_div, w_div_m1, w_half_m1;
  logic        w_stat_w1c;
  logic        w_unused;

  logic        w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [7:0]  w_tx_dout;
  logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0]  w_rx_dout;
  logic        w_fe_set, w_ov_set;

  assign w_acc      = cyc_i & stb_i & ~r_ack;
  assign w_wr       = w_acc & we_i;
  assign w_rd       = w_acc & ~we_i;
  assign w_stat_w1c = w_wr & (adr_i == UART_STAT) & sel_i[0];
  assign w_tx_push  = w_wr & (adr_i == UART_WDATA) & sel_i[0];
  assign w_rx_pop   = w_rd & (adr_i == UART_RDATA) & ~w_rx_empty;
  assign w_unused   = ^{sel_i[1], dat_i[15:8]};

  assign w_div     = eff_baud_div(r_baud_div);
  assign w_div_m1  = w_div - 16'd1;
  assign w_half_m1 = (w_div >> 1) - 16'd1;

  always_comb begin
    w_rdata = '0;
    if (!we_i) begin
      case (adr_i)
        UART_CTRL: w_rdata = {r_baud_div, 14'd0, r_rx_en, r_tx_en};
        UART_STAT: begin
          w_rdata[STAT_TX_FULL]   = w_tx_full;
          w_rdata[STAT_TX_EMPTY]  = w_tx_empty;
          w_rdata[STAT_RX_FULL]   = w_rx_full;
          w_rdata[STAT_RX_EMPTY]  = w_rx_empty;
          w_rdata[STAT_FRAME_ERR] = r_frame_err;
          w_rdata[STAT_OVERRUN]   = r_overrun;
        end
        UART_RDATA: if (!w_rx_empty) w_rdata = {24'd0, w_rx_dout};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_tx_en     <= 1'b0;
      r_rx_en     <= 1'b0;
      r_baud_div  <= 16'(DEFAULT_BAUD_DIV);
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_acc ? w_rdata : '0;
      if (w_wr && (adr_i == UART_CTRL)) begin
        if (sel_i[0]) begin
          r_tx_en <= dat_i[0];
          r_rx_en <= dat_i[1];
        end
        if (sel_i[2]) r_baud_div[7:0]  <= dat_i[23:16];
        if (sel_i[3]) r_baud_div[15:8] <= dat_i[31:24];
      end
      // A new error event in the same cycle as its W1C keeps the bit set.
      r_frame_err <= (r_frame_err & ~(w_stat_w1c & dat_i[STAT_FRAME_ERR])) | w_fe_set;
      r_overrun   <= (r_overrun   & ~(w_stat_w1c & dat_i[STAT_OVERRUN]))   | w_ov_set;
    end
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_tx_push),
    .din_i   (dat_i[7:0]),
    .pop_i   (w_tx_pop),
    .dout_o  (w_tx_dout),
    .full_o  (w_tx_full),
    .empty_o (w_tx_empty)
  );

  // ---------------- TX ----------------
  uart_state_t r_tx_state, w_tx_state_nxt;
  logic [15:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]  r_tx_bit, w_tx_bit_nxt;
  logic [7:0]  r_tx_shift, w_tx_shift_nxt;
  logic        r_tx_line, w_tx_line_nxt;
  logic        w_tx_go;

  assign w_tx_go = r_tx_en & ~w_tx_empty;

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt - 16'd1;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_line_nxt  = r_tx_line;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      ST_IDLE: begin
        w_tx_cnt_nxt  = r_tx_cnt;
        w_tx_line_nxt = 1'b1;
        if (w_tx_go) begin
          w_tx_pop       = 1'b1;
          w_tx_shift_nxt = w_tx_dout;
          w_tx_cnt_nxt   = w_div_m1;
          w_tx_line_nxt  = 1'b0;
          w_tx_state_nxt = ST_START;
        end
      end
      ST_START: if (r_tx_cnt == 16'd0) begin
        w_tx_cnt_nxt   = w_div_m1;
        w_tx_bit_nxt   = 3'd0;
        w_tx_line_nxt  = r_tx_shift[0];
        w_tx_state_nxt = ST_DATA;
      end
      ST_DATA: if (r_tx_cnt == 16'd0) begin
        w_tx_cnt_nxt = w_div_m1;
        if (r_tx_bit == 3'd7) begin
          w_tx_line_nxt  = 1'b1;
          w_tx_state_nxt = ST_STOP;
        end else begin
          w_tx_bit_nxt   = r_tx_bit + 3'd1;
          w_tx_shift_nxt = r_tx_shift >> 1;
          w_tx_line_nxt  = r_tx_shift[1];
        end
      end
      ST_STOP: if (r_tx_cnt == 16'd0) begin
        // Chain straight into the next start bit so frames have no idle gap.
        if (w_tx_go) begin
          w_tx_pop       = 1'b1;
          w_tx_shift_nxt = w_tx_dout;
          w_tx_cnt_nxt   = w_div_m1;
          w_tx_line_nxt  = 1'b0;
          w_tx_state_nxt = ST_START;
        end else begin
          w_tx_line_nxt  = 1'b1;
          w_tx_state_nxt = ST_IDLE;
        end
      end
      default: w_tx_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_line  <= w_tx_line_nxt;
    end
  end

  // ---------------- RX ----------------
  uart_state_t r_rx_state, w_rx_state_nxt;
  logic [15:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]  r_rx_bit, w_rx_bit_nxt;
  logic [7:0]  r_rx_shift, w_rx_shift_nxt;
  logic        r_rx_sync1, r_rx_sync2, r_rx_prev;
  logic        w_rx_fall;

  assign w_rx_fall = r_rx_prev & ~r_rx_sync2;

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt - 16'd1;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_push      = 1'b0;
    w_fe_set       = 1'b0;
    w_ov_set       = 1'b0;
    if (!r_rx_en) begin
      w_rx_state_nxt = ST_IDLE;
    end else begin
      case (r_rx_state)
        ST_IDLE: begin
          w_rx_cnt_nxt = r_rx_cnt;
          if (w_rx_fall) begin
            w_rx_cnt_nxt   = w_half_m1;
            w_rx_state_nxt = ST_START;
          end
        end
        ST_START: if (r_rx_cnt == 16'd0) begin
          w_rx_cnt_nxt   = w_div_m1;
          w_rx_bit_nxt   = 3'd0;
          w_rx_state_nxt = r_rx_sync2 ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (r_rx_cnt == 16'd0) begin
          w_rx_cnt_nxt   = w_div_m1;
          w_rx_shift_nxt = {r_rx_sync2, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) w_rx_state_nxt = ST_STOP;
          else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
        end
        ST_STOP: if (r_rx_cnt == 16'd0) begin
          w_rx_state_nxt = ST_IDLE;
          if (r_rx_sync2) begin
            w_rx_push = 1'b1;
            w_ov_set  = w_rx_full & ~w_rx_pop;
          end else begin
            w_fe_set  = 1'b1;
          end
        end
        default: w_rx_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_sync1 <= uart_rx_i;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_prev  <= r_rx_sync2;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_rx_push),
    .din_i   (r_rx_shift),
    .pop_i   (w_rx_pop),
    .dout_o  (w_rx_dout),
    .full_o  (w_rx_full),
    .empty_o (w_rx_empty)
  );

  assign ack_o     = r_ack;
  assign dat_o     = r_dat;
  assign uart_tx_o = r_tx_line;

endmodule
